// File: rtl/id_ex_pipe_reg.sv
// Decode/Execute pipeline register: one-cycle capture with stall (hold) and flush (bubble).
// Optional writeback bypass on the operand data when ID_EX_WB_BYPASS_EN is defined.
module id_ex_pipe_reg #(
  parameter int XLEN = 32,
  parameter int RIDX = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic            ValidD,
  input  logic            RegWriteD,
  input  logic [1:0]      ResultSrcD,
  input  logic            MemWriteD,
  input  logic            JumpD,
  input  logic            BranchD,
  input  logic [2:0]      ALUControlD,
  input  logic            ALUSrcD,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [RIDX-1:0] RS1D,
  input  logic [RIDX-1:0] RS2D,
  input  logic [RIDX-1:0] RdD,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [RIDX-1:0] RdW,
  input  logic [XLEN-1:0] ResultW,
  output logic            ValidE,
  output logic            RegWriteE,
  output logic [1:0]      ResultSrcE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic [2:0]      ALUControlE,
  output logic            ALUSrcE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [RIDX-1:0] RS1E,
  output logic [RIDX-1:0] RS2E,
  output logic [RIDX-1:0] RdE,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E
);

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic [1:0]      result_src;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic [2:0]      alu_control;
    logic            alu_src;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [RIDX-1:0] rs1;
    logic [RIDX-1:0] rs2;
    logic [RIDX-1:0] rd;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } ex_t;

  ex_t             ex_d, ex_q, load_v;
  logic [XLEN-1:0] rd1_fwd, rd2_fwd;

`ifdef ID_EX_WB_BYPASS_EN
  logic wb_live, hit1, hit2;

  // Same-cycle writeback to a source register being read overrides stale file data.
  assign wb_live = RegWriteW && (RdW != '0);
  assign hit1    = wb_live && (RdW == RS1D);
  assign hit2    = wb_live && (RdW == RS2D);
  assign rd1_fwd = hit1 ? ResultW : RD1D;
  assign rd2_fwd = hit2 ? ResultW : RD2D;
`else
  // Register file is write-first in this build; writeback ports are inert.
  wire unused_wb = &{1'b0, RegWriteW, RdW, ResultW};

  assign rd1_fwd = RD1D;
  assign rd2_fwd = RD2D;
`endif

  always_comb begin
    load_v             = '0;
    load_v.valid       = 1'b1;
    load_v.reg_write   = RegWriteD && (RdD != '0);
    load_v.result_src  = ResultSrcD;
    load_v.mem_write   = MemWriteD;
    load_v.jump        = JumpD;
    load_v.branch      = BranchD;
    load_v.alu_control = ALUControlD;
    load_v.alu_src     = ALUSrcD;
    load_v.rd1         = rd1_fwd;
    load_v.rd2         = rd2_fwd;
    load_v.rs1         = RS1D;
    load_v.rs2         = RS2D;
    load_v.rd          = RdD;
    load_v.imm_ext     = ImmExtD;
    load_v.pc          = PCD;
    load_v.pc_plus4    = PCPlus4D;
  end

  // Bubble is all-zero so the hazard unit never matches x0-indexed NOPs.
  always_comb begin
    ex_d = ex_q;
    if (FlushE)       ex_d = '0;
    else if (!StallE) ex_d = ValidD ? load_v : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  assign ValidE      = ex_q.valid;
  assign RegWriteE   = ex_q.reg_write;
  assign ResultSrcE  = ex_q.result_src;
  assign MemWriteE   = ex_q.mem_write;
  assign JumpE       = ex_q.jump;
  assign BranchE     = ex_q.branch;
  assign ALUControlE = ex_q.alu_control;
  assign ALUSrcE     = ex_q.alu_src;
  assign RD1E        = ex_q.rd1;
  assign RD2E        = ex_q.rd2;
  assign RS1E        = ex_q.rs1;
  assign RS2E        = ex_q.rs2;
  assign RdE         = ex_q.rd;
  assign ImmExtE     = ex_q.imm_ext;
  assign PCE         = ex_q.pc;
  assign PCPlus4E    = ex_q.pc_plus4;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: vector table plus stall/reset sequences, scoreboard-checked.
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic [1:0]  rsrc;
    logic        mw;
    logic        j;
    logic        b;
    logic [2:0]  aluc;
    logic        asrc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ex_t;

  typedef struct {
    logic             rst, stall, flush;
    logic             wb_we;
    logic [4:0]       wb_rd;
    logic [31:0]      wb_res;
    ex_t              d;
    ex_t              want;
    logic [8*12-1:0]  name;
  } vec_t;

`ifdef ID_EX_WB_BYPASS_EN
  localparam logic [31:0] BYPV = 32'h0000_ABCD;
`else
  localparam logic [31:0] BYPV = 32'h0000_0011;
`endif

  logic        clk = 1'b0;
  logic        rst, StallE, FlushE, RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  ex_t         d_in, e_out;

  logic        ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD;
  logic [31:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [4:0]  RS1D, RS2D, RdD;
  logic        ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  RS1E, RS2E, RdE;

  assign {ValidD, RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUControlD, ALUSrcD,
          RD1D, RD2D, RS1D, RS2D, RdD, ImmExtD, PCD, PCPlus4D} = d_in;
  assign e_out = {ValidE, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE,
                  RD1E, RD2E, RS1E, RS2E, RdE, ImmExtE, PCE, PCPlus4E};

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.XLEN(32), .RIDX(5)) dut (
    .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
    .ValidD(ValidD), .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
    .JumpD(JumpD), .BranchD(BranchD), .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD),
    .RD1D(RD1D), .RD2D(RD2D), .RS1D(RS1D), .RS2D(RS2D), .RdD(RdD),
    .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .RD1E(RD1E), .RD2E(RD2E), .RS1E(RS1E), .RS2E(RS2E), .RdE(RdE),
    .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E)
  );

  ex_t             exp_q[$];
  logic [8*12-1:0] name_q[$];
  int              checks = 0;
  int              passed = 0;

  // Each pushed expectation is due at the negedge after the posedge that follows the push.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ex_t             w;
      logic [8*12-1:0] n;
      w = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (e_out === w) passed++;
      else $display("FAIL %0s: got %h expected %h", n, e_out, w);
    end
  end

  function automatic ex_t ins(input logic rw, input logic [1:0] rsrc, input logic mw, j, b,
                              input logic [2:0] aluc, input logic asrc,
                              input logic [4:0] rs1, rs2, rd,
                              input logic [31:0] rd1, rd2, imm, pc);
    ex_t e;
    e = '{valid:1'b1, rw:rw, rsrc:rsrc, mw:mw, j:j, b:b, aluc:aluc, asrc:asrc,
          rd1:rd1, rd2:rd2, rs1:rs1, rs2:rs2, rd:rd, imm:imm, pc:pc, pc4:pc + 32'd4};
    return e;
  endfunction

  function automatic vec_t mkv(input logic r, s, f, input ex_t d, input ex_t want,
                               input logic [8*12-1:0] name);
    vec_t v;
    v = '{rst:r, stall:s, flush:f, wb_we:1'b0, wb_rd:5'd0, wb_res:32'h0,
          d:d, want:want, name:name};
    return v;
  endfunction

  task automatic apply(input vec_t v);
    @(negedge clk);
    #1;
    rst = v.rst; StallE = v.stall; FlushE = v.flush;
    RegWriteW = v.wb_we; RdW = v.wb_rd; ResultW = v.wb_res;
    d_in = v.d;
    exp_q.push_back(v.want);
    name_q.push_back(v.name);
  endtask

  ex_t  ONES, Z, ADD, A, B, X0, X0W, NV, BYP, BYPW, BYP2, BYP2W, BYPN;
  vec_t tbl[13];
  vec_t v;

  initial begin
    rst = 1'b1; StallE = 1'b0; FlushE = 1'b0;
    RegWriteW = 1'b0; RdW = '0; ResultW = '0; d_in = '1;

    ONES = '1;
    Z    = '0;
    ADD  = ins(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3,
               32'd5, 32'd7, 32'd0, 32'h100);
    A    = ins(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 5'd6, 5'd0, 5'd8,
               32'h1000, 32'h0, 32'h10, 32'h104);
    B    = ins(1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 3'b111, 1'b0, 5'd31, 5'd17, 5'd12,
               32'hDEAD_BEEF, 32'hCAFE_F00D, 32'hFFFF_FFF0, 32'h2000);
    X0   = ins(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 5'd1, 5'd2, 5'd0,
               32'd9, 32'd10, 32'd0, 32'h300);
    X0W  = X0; X0W.rw = 1'b0;
    NV   = B;  NV.valid = 1'b0;
    BYP  = ins(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 5'd4, 5'd4, 5'd5,
               32'h11, 32'h11, 32'd0, 32'h400);
    BYPW = BYP; BYPW.rd1 = BYPV; BYPW.rd2 = BYPV;
    BYP2 = BYP; BYP2.rs2 = 5'd9; BYP2.rd2 = 32'h22;
    BYP2W = BYP2; BYP2W.rd1 = BYPV;
    BYPN = BYP;

    tbl[0]  = mkv(1'b1, 1'b0, 1'b0, ONES, Z,   "rst_a");
    tbl[1]  = mkv(1'b1, 1'b0, 1'b0, ONES, Z,   "rst_b");
    tbl[2]  = mkv(1'b0, 1'b0, 1'b0, ADD,  ADD, "add");
    tbl[3]  = mkv(1'b0, 1'b0, 1'b0, A,    A,   "load_a");
    tbl[4]  = mkv(1'b0, 1'b1, 1'b1, B,    Z,   "stall_flush");
    tbl[5]  = mkv(1'b0, 1'b0, 1'b0, X0,   X0W, "x0_write");
    tbl[6]  = mkv(1'b0, 1'b0, 1'b0, NV,   Z,   "valid0");
    tbl[7]  = mkv(1'b0, 1'b0, 1'b0, B,    B,   "load_b");
    tbl[8]  = mkv(1'b0, 1'b0, 1'b1, A,    Z,   "flush");
    tbl[9]  = mkv(1'b0, 1'b0, 1'b0, BYP,  BYPW, "byp_both");
    tbl[9].wb_we = 1'b1; tbl[9].wb_rd = 5'd4; tbl[9].wb_res = 32'hABCD;
    tbl[10] = mkv(1'b0, 1'b0, 1'b0, BYP,  BYP, "byp_rdw0");
    tbl[10].wb_we = 1'b1; tbl[10].wb_rd = 5'd0; tbl[10].wb_res = 32'hABCD;
    tbl[11] = mkv(1'b0, 1'b0, 1'b0, BYP2, BYP2W, "byp_rs1");
    tbl[11].wb_we = 1'b1; tbl[11].wb_rd = 5'd4; tbl[11].wb_res = 32'hABCD;
    tbl[12] = mkv(1'b0, 1'b0, 1'b0, BYPN, BYPN, "byp_nowe");
    tbl[12].wb_we = 1'b0; tbl[12].wb_rd = 5'd4; tbl[12].wb_res = 32'hABCD;

    for (int i = 0; i < 13; i++) apply(tbl[i]);

    // Stall holds A across three cycles of new D values, then B lands one cycle later.
    apply(mkv(1'b0, 1'b0, 1'b0, A, A, "seq_a"));
    for (int i = 0; i < 3; i++) apply(mkv(1'b0, 1'b1, 1'b0, B, A, "stall_hold"));
    apply(mkv(1'b0, 1'b0, 1'b0, B, B, "stall_rel"));

    // Stall ignores a matching writeback: held data must not be rewritten.
    apply(mkv(1'b0, 1'b0, 1'b0, BYP, BYP, "pre_hold"));
    v = mkv(1'b0, 1'b1, 1'b0, A, BYP, "stall_nobyp");
    v.wb_we = 1'b1; v.wb_rd = 5'd4; v.wb_res = 32'h5555;
    apply(v);

    // Reset beats stall; releasing reset while stalled keeps the zero state.
    apply(mkv(1'b0, 1'b0, 1'b0, A, A, "seq_a2"));
    apply(mkv(1'b1, 1'b1, 1'b0, B, Z, "rst_stall"));
    apply(mkv(1'b0, 1'b1, 1'b0, B, Z, "post_rst"));
    apply(mkv(1'b0, 1'b0, 1'b0, ADD, ADD, "resume"));
    apply(mkv(1'b1, 1'b0, 1'b1, A, Z, "rst_flush"));

    begin
      int budget;
      budget = 10;
      while (exp_q.size() > 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      #1;
      if (exp_q.size() > 0) begin
        checks++;
        $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
